// File: rtl/bsg_level_shift_pkg.sv
// Shared types for the level-shift sink receiver: controller state encoding
// and the width of the optional isolation-event counter.
package bsg_level_shift_pkg;

    typedef enum logic [1:0] {
        eIsolated = 2'd0,
        eSettle   = 2'd1,
        eActive   = 2'd2
    } state_e;

    localparam int iso_cnt_width_gp = 16;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready in, valid/yumi out buffer. Ready depends only on the
// current occupancy, so a full buffer refuses a beat even while it is dequeued.
module bsg_two_fifo #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         count_r;
    logic               enq;
    logic               deq;

    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[rd_ptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Entries are cleared on reset so the head reads zero before any beat arrives.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (enq) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (deq) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            if (enq && !deq) begin
                count_r <= count_r + 2'd1;
            end else if (deq && !enq) begin
                count_r <= count_r - 2'd1;
            end
        end
    end

endmodule

// File: rtl/bsg_level_shift_sink_rx.sv
// v1-domain receiver for beats from the switchable v0 domain: waits out a settle
// interval after v0 enable, then buffers beats. BSG_LEVEL_SHIFT_SINK_RX_ISO_CNT_EN adds iso_events_o.
module bsg_level_shift_sink_rx
    import bsg_level_shift_pkg::*;
#(
    parameter int width_p         = 32,
    parameter int settle_cycles_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v0_en_i,
    input  logic               v0_v_i,
    input  logic [width_p-1:0] v0_data_i,
    output logic               v0_ready_o,
    output logic               v1_v_o,
    output logic [width_p-1:0] v1_data_o,
    input  logic               v1_yumi_i,
    output logic               isolated_o
`ifdef BSG_LEVEL_SHIFT_SINK_RX_ISO_CNT_EN
    ,
    output logic [iso_cnt_width_gp-1:0] iso_events_o
`endif
);

    localparam int cnt_width_lp = $clog2(settle_cycles_p + 1);

    state_e                  state_r;
    state_e                  state_n;
    logic [cnt_width_lp-1:0] cnt_r;
    logic [cnt_width_lp-1:0] cnt_n;
    logic                    fifo_ready;
    logic                    enq;

    // Losing enable wins over everything; the counter is reloaded on every new rise.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        case (state_r)
            eIsolated: begin
                if (v0_en_i) begin
                    state_n = eSettle;
                    cnt_n   = cnt_width_lp'(settle_cycles_p - 1);
                end
            end
            eSettle: begin
                if (!v0_en_i) begin
                    state_n = eIsolated;
                end else if (cnt_r != '0) begin
                    cnt_n = cnt_r - cnt_width_lp'(1);
                end else begin
                    state_n = eActive;
                end
            end
            eActive: begin
                if (!v0_en_i) begin
                    state_n = eIsolated;
                end
            end
            default: state_n = eIsolated;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIsolated;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    assign v0_ready_o = (state_r == eActive) & v0_en_i & fifo_ready;
    assign enq        = v0_v_i & v0_ready_o;
    assign isolated_o = (state_r == eIsolated);

    bsg_two_fifo #(
        .width_p(width_p)
    ) fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (enq),
        .data_i (v0_data_i),
        .ready_o(fifo_ready),
        .v_o    (v1_v_o),
        .data_o (v1_data_o),
        .yumi_i (v1_yumi_i)
    );

`ifdef BSG_LEVEL_SHIFT_SINK_RX_ISO_CNT_EN
    logic [iso_cnt_width_gp-1:0] iso_cnt_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            iso_cnt_r <= '0;
        end else if (state_r == eActive && state_n == eIsolated && iso_cnt_r != '1) begin
            iso_cnt_r <= iso_cnt_r + 1'b1;
        end
    end

    assign iso_events_o = iso_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_level_shift_sink_rx.sv
// Bench for bsg_level_shift_sink_rx: directed scenarios plus random traffic,
// checked against a model built on "consecutive enable cycles" and a beat queue.
module tb_bsg_level_shift_sink_rx;

    localparam int width_p  = 32;
    localparam int settle_p = 4;

    logic               clk;
    logic               reset;
    logic               v0_en;
    logic               v0_v;
    logic [width_p-1:0] v0_data;
    logic               v0_ready;
    logic               v1_v;
    logic [width_p-1:0] v1_data;
    logic               v1_yumi;
    logic               isolated;
`ifdef BSG_LEVEL_SHIFT_SINK_RX_ISO_CNT_EN
    logic [15:0]        iso_events;
`endif

    int checks = 0;
    int errors = 0;

    // Model: en_run counts edges since enable was last seen low (or reset);
    // the block is active once that run exceeds the settle interval.
    int               en_run;
    logic [31:0]      q[$];
    int               iso_cnt;

    bsg_level_shift_sink_rx #(
        .width_p        (width_p),
        .settle_cycles_p(settle_p)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .v0_en_i   (v0_en),
        .v0_v_i    (v0_v),
        .v0_data_i (v0_data),
        .v0_ready_o(v0_ready),
        .v1_v_o    (v1_v),
        .v1_data_o (v1_data),
        .v1_yumi_i (v1_yumi),
        .isolated_o(isolated)
`ifdef BSG_LEVEL_SHIFT_SINK_RX_ISO_CNT_EN
        ,
        .iso_events_o(iso_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle from the negedge, check against the model, then advance the model on the posedge.
    task automatic applyStimulus(input logic rst, input logic en, input logic v,
                                 input logic [31:0] d, input logic y);
        logic exp_ready;
        logic yumi;
        yumi    = y && (q.size() > 0);
        reset   = rst;
        v0_en   = en;
        v0_v    = v;
        v0_data = v ? d : 32'h0;
        v1_yumi = yumi;
        #1;
        exp_ready = (en_run > settle_p) && en && (q.size() < 2);
        checkOutput("ready", 32'(v0_ready), 32'(exp_ready));
        checkOutput("v1_v", 32'(v1_v), 32'(q.size() > 0));
        checkOutput("isolated", 32'(isolated), 32'(en_run == 0));
        if (q.size() > 0) begin
            checkOutput("v1_data", v1_data, q[0]);
        end
`ifdef BSG_LEVEL_SHIFT_SINK_RX_ISO_CNT_EN
        checkOutput("iso_events", 32'(iso_events), 32'(iso_cnt));
`endif
        @(posedge clk);
        if (rst) begin
            en_run  = 0;
            iso_cnt = 0;
            q.delete();
        end else begin
            if (yumi) void'(q.pop_front());
            if (v && exp_ready) q.push_back(v0_data);
            if (en) begin
                if (en_run < 1000) en_run++;
            end else begin
                if (en_run > settle_p && iso_cnt < 16'hFFFF) iso_cnt++;
                en_run = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        v0_en   = 1'b0;
        v0_v    = 1'b0;
        v0_data = '0;
        v1_yumi = 1'b0;
        en_run  = 0;
        iso_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset with enable held high, then the full settle interval.
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("rst_data", v1_data, 32'h0);
        repeat (7) applyStimulus(0, 1, 0, 0, 0);

        // Enable glitch part-way through settle forces a full restart.
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (6) applyStimulus(0, 1, 0, 0, 0);

        // Back-to-back stream with the consumer taking every cycle.
        for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 1, 32'(i), 1);
        repeat (2) applyStimulus(0, 1, 0, 0, 1);

        // Fill the buffer, refuse the third beat, then accept it after one yumi.
        applyStimulus(0, 1, 1, 32'hA, 0);
        applyStimulus(0, 1, 1, 32'hB, 0);
        applyStimulus(0, 1, 1, 32'hC, 0);
        applyStimulus(0, 1, 1, 32'hC, 1);
        applyStimulus(0, 1, 1, 32'hC, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 1);

        // Enable drops with two beats buffered: they still drain, nothing new enters.
        applyStimulus(0, 1, 1, 32'hA, 0);
        applyStimulus(0, 1, 1, 32'hB, 0);
        repeat (4) applyStimulus(0, 0, 1, 32'hD, 1);

        // Three active-to-isolated transitions.
        for (int k = 0; k < 3; k++) begin
            repeat (6) applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
`ifdef BSG_LEVEL_SHIFT_SINK_RX_ISO_CNT_EN
        checkOutput("iso_three", 32'(iso_events), 32'd3);
`endif

        // Mid-operation reset flushes buffered data.
        repeat (6) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h55, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("flush_v", 32'(v1_v), 32'd0);
`ifdef BSG_LEVEL_SHIFT_SINK_RX_ISO_CNT_EN
        checkOutput("iso_reset", 32'(iso_events), 32'd0);
`endif

        // Random traffic with occasional enable drops and resets.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 399) == 0),
                          ($urandom_range(0, 11) != 0),
                          1'($urandom_range(0, 1)),
                          $urandom,
                          ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
